beehive_noc_fbits_buffered_splitter: RTL

//  Packet-aware NoC splitter with per-target elastic buffering. Sits between a tile's

---
 rtl/beehive_noc_fbits_buffered_splitter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/beehive_noc_fbits_buffered_splitter.sv
// Packet-aware NoC splitter: steers whole packets by header fbits into per-target
// show-ahead FIFOs; packets matching no target are consumed and counted as drops.
module beehive_noc_fbits_buffered_splitter #(
    parameter int unsigned DATA_W      = 512,
    parameter int unsigned NUM_TARGETS = 2,
    parameter int unsigned LOG2_DEPTH  = 4,
    parameter int unsigned FBITS_LSB   = 0,
    parameter int unsigned FBITS_W     = 4,
    parameter int unsigned LEN_LSB     = FBITS_W,
    parameter int unsigned LEN_W       = 8,
    parameter logic [NUM_TARGETS*FBITS_W-1:0] TARGET_FBITS = '0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                src_val,
    input  logic [DATA_W-1:0]                   src_data,
    output logic                                src_rdy,
    output logic [NUM_TARGETS-1:0]              dst_val,
    output logic [NUM_TARGETS*DATA_W-1:0]       dst_data,
    input  logic [NUM_TARGETS-1:0]              dst_rdy,
    output logic [NUM_TARGETS*(LOG2_DEPTH+1)-1:0] dst_occupancy,
    output logic [31:0]                         drop_cnt
);

    localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
    localparam int unsigned OCC_W = LOG2_DEPTH + 1;
    localparam int unsigned SEL_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

    typedef enum logic {ST_HDR, ST_BODY} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               drop_q, drop_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [31:0]        drop_cnt_q, drop_cnt_d;

    logic [FBITS_W-1:0] hdr_fbits;
    logic [LEN_W-1:0]   hdr_len;
    logic               hit;
    logic [SEL_W-1:0]   hit_idx;
    logic               cnt_inc;

    logic [NUM_TARGETS-1:0] full;
    logic [NUM_TARGETS-1:0] wr_en;
    logic [NUM_TARGETS-1:0] rd_en;

    assign hdr_fbits = src_data[FBITS_LSB +: FBITS_W];
    assign hdr_len   = src_data[LEN_LSB +: LEN_W];
    assign drop_cnt  = drop_cnt_q;

    // Lowest-index match wins when several targets share an fbits value.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
            if (!hit && hdr_fbits == TARGET_FBITS[i*FBITS_W +: FBITS_W]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        drop_d     = drop_q;
        rem_d      = rem_q;
        drop_cnt_d = drop_cnt_q;
        src_rdy    = 1'b0;
        wr_en      = '0;
        cnt_inc    = 1'b0;
        case (state_q)
            ST_HDR: begin
                src_rdy = ~hit | ~full[hit_idx];
                if (src_val && src_rdy) begin
                    wr_en[hit_idx] = hit;
                    sel_d          = hit_idx;
                    drop_d         = ~hit;
                    rem_d          = hdr_len;
                    if (hdr_len != '0) state_d = ST_BODY;
                    else               cnt_inc = ~hit;
                end
            end
            ST_BODY: begin
                src_rdy = drop_q | ~full[sel_q];
                if (src_val && src_rdy) begin
                    wr_en[sel_q] = ~drop_q;
                    rem_d        = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_HDR;
                        cnt_inc = drop_q;
                    end
                end
            end
            default: state_d = ST_HDR;
        endcase
        if (cnt_inc && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HDR;
            sel_q      <= '0;
            drop_q     <= 1'b0;
            rem_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            drop_q     <= drop_d;
            rem_q      <= rem_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_fifo
        logic [DATA_W-1:0]     mem_q [DEPTH];
        logic [LOG2_DEPTH-1:0] wptr_q, rptr_q;
        logic [OCC_W-1:0]      occ_q;

        // full uses registered occupancy only, so a same-cycle read never frees a slot.
        assign full[g]  = (occ_q == OCC_W'(DEPTH));
        assign dst_val[g] = (occ_q != '0);
        assign rd_en[g] = dst_val[g] & dst_rdy[g];
        assign dst_data[g*DATA_W +: DATA_W]    = mem_q[rptr_q];
        assign dst_occupancy[g*OCC_W +: OCC_W] = occ_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wptr_q <= '0;
                rptr_q <= '0;
                occ_q  <= '0;
            end else begin
                if (wr_en[g]) wptr_q <= wptr_q + LOG2_DEPTH'(1);
                if (rd_en[g]) rptr_q <= rptr_q + LOG2_DEPTH'(1);
                case ({wr_en[g], rd_en[g]})
                    2'b10:   occ_q <= occ_q + OCC_W'(1);
                    2'b01:   occ_q <= occ_q - OCC_W'(1);
                    default: occ_q <= occ_q;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (wr_en[g]) mem_q[wptr_q] <= src_data;
        end
    end

endmodule
